// File: rtl/symbol_rx_deserializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// symbol_rx_deserializer_if : serial line in, checked symbol + status out
// Revision: 1.0
// ---------------------------------------------------------------------------
interface symbol_rx_deserializer_if;
  logic       rx;
  logic [6:0] sym;
  logic       sym_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  modport master (
    input  rx,
    output sym, sym_valid, parity_err, frame_err, err_count, busy
  );

  modport slave (
    output rx,
    input  sym, sym_valid, parity_err, frame_err, err_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/symbol_rx_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// symbol_rx_deserializer : 7-bit odd-parity serial receiver feeding the checker
// Revision: 1.0
// ---------------------------------------------------------------------------
module symbol_rx_deserializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  symbol_rx_deserializer_if.master  bus
);

  localparam int         HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [7:0] HALF_LOAD = 8'(HALF_BIT - 1);
  localparam logic [7:0] BIT_LOAD  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  logic [7:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       parity_ok_q, parity_ok_d;
  logic [6:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_count_q, err_count_d;
  logic       busy_q, busy_d;
  logic       sample;
  logic       err_inc;

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = bus.rx;
    rx_s_d       = rx_meta_q;
    cyc_cnt_d    = cyc_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_ok_d  = parity_ok_q;
    sym_d        = sym_q;
    sym_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    err_inc      = 1'b0;
    sample       = (cyc_cnt_q == 8'd0);

    // Every bit-timed state counts down to a mid-bit sample, then reloads.
    if (state_q != S_IDLE && state_q != S_BREAK) begin
      cyc_cnt_d = sample ? BIT_LOAD : cyc_cnt_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          cyc_cnt_d = HALF_LOAD;
        end
      end
      S_START: begin
        if (sample) begin
          state_d   = rx_s_q ? S_IDLE : S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {shift_q[5:0], rx_s_q};
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_d = 3'd0;
            state_d   = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          parity_ok_d = ^{shift_q, rx_s_q};
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
            state_d     = S_BREAK;
          end else if (parity_ok_q) begin
            sym_d       = shift_q;
            sym_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            parity_err_d = 1'b1;
            err_inc      = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_inc && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cyc_cnt_q    <= 8'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      parity_ok_q  <= 1'b0;
      sym_q        <= 7'd0;
      sym_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_ok_q  <= parity_ok_d;
      sym_q        <= sym_d;
      sym_valid_q  <= sym_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sym        = sym_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_count  = err_count_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_symbol_rx_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_symbol_rx_deserializer : directed frame tests, CLKS_PER_BIT = 4
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_symbol_rx_deserializer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  // Pulse history gathered on the falling edge.
  int         sv_cyc_q[$];
  logic [6:0] sv_sym_q[$];
  int         pe_cnt, fe_cnt, multi_cnt, busy_last;
  logic [7:0] err_at_pulse;

  symbol_rx_deserializer_if bus_if ();

  symbol_rx_deserializer #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_if.sym_valid === 1'b1) begin
      sv_cyc_q.push_back(cyc);
      sv_sym_q.push_back(bus_if.sym);
    end
    if (bus_if.parity_err === 1'b1) pe_cnt++;
    if (bus_if.frame_err === 1'b1) fe_cnt++;
    if (bus_if.parity_err === 1'b1 || bus_if.frame_err === 1'b1) err_at_pulse = bus_if.err_count;
    if (int'(bus_if.sym_valid) + int'(bus_if.parity_err) + int'(bus_if.frame_err) > 1) multi_cnt++;
    if (bus_if.busy === 1'b1) busy_last = cyc;
  end

  task automatic clear_mon();
    sv_cyc_q.delete();
    sv_sym_q.delete();
    pe_cnt = 0;
    fe_cnt = 0;
    multi_cnt = 0;
  endtask

  task automatic drive_bits(input logic b, input int n);
    bus_if.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop, output int start_cyc);
    start_cyc = cyc;
    drive_bits(1'b0, 4);
    for (int i = 6; i >= 0; i--) drive_bits(d[i], 4);
    drive_bits(par, 4);
    drive_bits(stop, 4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++; if (bus_if.sym !== 7'd0) begin mismatched++; $display("FAIL reset_sym: got %b expected 0000000", bus_if.sym); end
    compared++; if (bus_if.sym_valid !== 1'b0) begin mismatched++; $display("FAIL reset_sym_valid: got %b expected 0", bus_if.sym_valid); end
    compared++; if (bus_if.parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_parity_err: got %b expected 0", bus_if.parity_err); end
    compared++; if (bus_if.frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b expected 0", bus_if.frame_err); end
    compared++; if (bus_if.err_count !== 8'd0) begin mismatched++; $display("FAIL reset_err_count: got %0d expected 0", bus_if.err_count); end
    compared++; if (bus_if.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    busy_last = -1;
    clear_mon();
    repeat (50) @(negedge clk);
    compared++; if (busy_last !== -1) begin mismatched++; $display("FAIL idle_busy: busy seen at cycle %0d expected never", busy_last); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_mon();
    send_frame(7'b1011000, 1'b0, 1'b1, s1);
    send_frame(7'b1101011, 1'b0, 1'b1, s2);
    drive_bits(1'b1, 4);
    compared++; if (sv_cyc_q.size() !== 2) begin mismatched++; $display("FAIL b2b_pulses: got %0d expected 2", sv_cyc_q.size()); end
    if (sv_cyc_q.size() >= 1) begin
      // rx edge -> t0 is 2 clocks, pulse at t0+39
      compared++; if (sv_cyc_q[0] !== s1 + 41) begin mismatched++; $display("FAIL b2b_latency: got cycle %0d expected %0d", sv_cyc_q[0], s1 + 41); end
      compared++; if (sv_sym_q[0] !== 7'b1011000) begin mismatched++; $display("FAIL b2b_sym1: got %b expected 1011000", sv_sym_q[0]); end
    end
    if (sv_cyc_q.size() == 2) begin
      compared++; if (sv_cyc_q[1] - sv_cyc_q[0] !== 40) begin mismatched++; $display("FAIL b2b_spacing: got %0d expected 40", sv_cyc_q[1] - sv_cyc_q[0]); end
      compared++; if (sv_sym_q[1] !== 7'b1101011) begin mismatched++; $display("FAIL b2b_sym2: got %b expected 1101011", sv_sym_q[1]); end
    end
    compared++; if (bus_if.sym !== 7'b1101011) begin mismatched++; $display("FAIL b2b_sym_hold: got %b expected 1101011", bus_if.sym); end
    compared++; if (pe_cnt + fe_cnt !== 0) begin mismatched++; $display("FAIL b2b_errs: got %0d expected 0", pe_cnt + fe_cnt); end
  endtask

  task automatic test_parity_error();
    int s;
    clear_mon();
    send_frame(7'b0101000, 1'b0, 1'b1, s);
    drive_bits(1'b1, 4);
    compared++; if (pe_cnt !== 1) begin mismatched++; $display("FAIL perr_pulses: got %0d expected 1", pe_cnt); end
    compared++; if (sv_cyc_q.size() !== 0) begin mismatched++; $display("FAIL perr_sym_valid: got %0d pulses expected 0", sv_cyc_q.size()); end
    compared++; if (fe_cnt !== 0) begin mismatched++; $display("FAIL perr_frame_err: got %0d expected 0", fe_cnt); end
    compared++; if (bus_if.sym !== 7'b1101011) begin mismatched++; $display("FAIL perr_sym_hold: got %b expected 1101011", bus_if.sym); end
    compared++; if (bus_if.err_count !== 8'd1) begin mismatched++; $display("FAIL perr_count: got %0d expected 1", bus_if.err_count); end
    compared++; if (err_at_pulse !== 8'd1) begin mismatched++; $display("FAIL perr_count_timing: got %0d expected 1", err_at_pulse); end
  endtask

  task automatic test_framing_error();
    int s, r;
    clear_mon();
    send_frame(7'b0001100, 1'b1, 1'b0, s);
    drive_bits(1'b0, 12);
    r = cyc;
    drive_bits(1'b1, 6);
    compared++; if (fe_cnt !== 1) begin mismatched++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt); end
    compared++; if (pe_cnt !== 0) begin mismatched++; $display("FAIL ferr_parity_err: got %0d expected 0", pe_cnt); end
    compared++; if (bus_if.err_count !== 8'd2) begin mismatched++; $display("FAIL ferr_count: got %0d expected 2", bus_if.err_count); end
    compared++; if (err_at_pulse !== 8'd2) begin mismatched++; $display("FAIL ferr_count_timing: got %0d expected 2", err_at_pulse); end
    // rx_s rises at r+2; busy is still high that cycle and drops the next
    compared++; if (busy_last !== r + 2) begin mismatched++; $display("FAIL ferr_busy_release: got cycle %0d expected %0d", busy_last, r + 2); end
    clear_mon();
    send_frame(7'b0110010, 1'b0, 1'b1, s);
    drive_bits(1'b1, 4);
    compared++; if (sv_cyc_q.size() !== 1) begin mismatched++; $display("FAIL ferr_recover_pulses: got %0d expected 1", sv_cyc_q.size()); end
    compared++; if (bus_if.sym !== 7'b0110010) begin mismatched++; $display("FAIL ferr_recover_sym: got %b expected 0110010", bus_if.sym); end
  endtask

  task automatic test_false_start();
    int s;
    clear_mon();
    busy_last = -1;
    s = cyc;
    drive_bits(1'b0, 1);
    drive_bits(1'b1, 10);
    compared++; if (sv_cyc_q.size() + pe_cnt + fe_cnt !== 0) begin mismatched++; $display("FAIL false_start_pulses: got %0d expected 0", sv_cyc_q.size() + pe_cnt + fe_cnt); end
    compared++; if (bus_if.err_count !== 8'd2) begin mismatched++; $display("FAIL false_start_count: got %0d expected 2", bus_if.err_count); end
    // t0 = s+2; last busy cycle is the START sample at t0+HALF_BIT
    compared++; if (busy_last !== s + 4) begin mismatched++; $display("FAIL false_start_busy: got cycle %0d expected %0d", busy_last, s + 4); end
  endtask

  task automatic test_reset_midframe();
    int s;
    logic [6:0] d;
    d = 7'b1010101;
    clear_mon();
    bus_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 6; i >= 4; i--) drive_bits(d[i], 4);
    drive_bits(d[3], 2);
    compared++; if (bus_if.busy !== 1'b1) begin mismatched++; $display("FAIL midframe_busy_before: got %b expected 1", bus_if.busy); end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (bus_if.sym !== 7'd0) begin mismatched++; $display("FAIL async_reset_sym: got %b expected 0000000", bus_if.sym); end
    compared++; if (bus_if.err_count !== 8'd0) begin mismatched++; $display("FAIL async_reset_count: got %0d expected 0", bus_if.err_count); end
    compared++; if (bus_if.busy !== 1'b0) begin mismatched++; $display("FAIL async_reset_busy: got %b expected 0", bus_if.busy); end
    compared++; if ({bus_if.sym_valid, bus_if.parity_err, bus_if.frame_err} !== 3'b000) begin mismatched++; $display("FAIL async_reset_pulses: got %b expected 000", {bus_if.sym_valid, bus_if.parity_err, bus_if.frame_err}); end
    bus_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    clear_mon();
    send_frame(7'b0100011, 1'b0, 1'b1, s);
    drive_bits(1'b1, 4);
    compared++; if (sv_cyc_q.size() !== 1) begin mismatched++; $display("FAIL post_reset_pulses: got %0d expected 1", sv_cyc_q.size()); end
    compared++; if (bus_if.sym !== 7'b0100011) begin mismatched++; $display("FAIL post_reset_sym: got %b expected 0100011", bus_if.sym); end
  endtask

  task automatic test_saturation();
    int s;
    clear_mon();
    for (int i = 0; i < 254; i++) send_frame(7'b0000000, 1'b0, 1'b1, s);
    drive_bits(1'b1, 4);
    compared++; if (bus_if.err_count !== 8'd254) begin mismatched++; $display("FAIL sat_count_254: got %0d expected 254", bus_if.err_count); end
    for (int i = 0; i < 3; i++) send_frame(7'b0000000, 1'b0, 1'b1, s);
    drive_bits(1'b1, 4);
    compared++; if (bus_if.err_count !== 8'd255) begin mismatched++; $display("FAIL sat_count_255: got %0d expected 255", bus_if.err_count); end
    compared++; if (pe_cnt !== 257) begin mismatched++; $display("FAIL sat_pulses: got %0d expected 257", pe_cnt); end
    compared++; if (multi_cnt !== 0) begin mismatched++; $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", multi_cnt); end
  endtask

  initial begin
    bus_if.rx = 1'b1;
    reset = 1'b1;
    pe_cnt = 0;
    fe_cnt = 0;
    multi_cnt = 0;
    busy_last = -1;
    err_at_pulse = 8'd0;
    test_reset();
    test_back_to_back();
    test_parity_error();
    test_framing_error();
    test_false_start();
    test_reset_midframe();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
